// File: rtl/seq_detector_pkg.sv
// Shared defaults, types and helpers for the parametrised serial sequence detector.
// No logic; constants and a pure function only.
// Imported by seq_detector_param and seqdet_hist.
package seq_detector_pkg;

    localparam int          DEF_PAT_LEN = 4;
    localparam logic [31:0] DEF_PATTERN = 32'h0000_000B;   // 4'b1011, MSB received first
    localparam int          DEF_CNT_W   = 8;

    // Largest supported pattern length; fill must be able to hold 0..MAX_PAT_LEN.
    localparam int MAX_PAT_LEN = 32;

    typedef logic [$clog2(MAX_PAT_LEN+1)-1:0] fill_t;

    // Saturating increment: stays at max_v once reached, never wraps.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max_v);
        return (cnt >= max_v) ? max_v : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/seqdet_hist.sv
// History shift register plus saturating count of bits received since reset/flush.
// Latency: hist and fill update on the clock edge after shift/flush.
// No backpressure: shift is taken every cycle it is high; flush only clears fill.
module seqdet_hist
    import seq_detector_pkg::*;
#(
    parameter int PAT_LEN = DEF_PAT_LEN
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i,
    input  logic               shift,
    input  logic               flush,
    output logic [PAT_LEN-1:0] hist,
    output fill_t              fill,
    output logic               full
);

    localparam fill_t FILL_MAX = fill_t'(PAT_LEN);

    // Shift the new bit in at the LSB; fill counts up to PAT_LEN, flush restarts it.
    // Flush keeps hist so a shift in the same cycle still lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
        end else begin
            if (shift) begin
                hist <= {hist[PAT_LEN-2:0], i};
            end
            if (flush) begin
                fill <= '0;
            end else if (shift && (fill != FILL_MAX)) begin
                fill <= fill + fill_t'(1);
            end
        end
    end

    // The window is complete once the next shifted bit arrives.
    assign full = (fill >= (FILL_MAX - fill_t'(1)));

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector: registered one-cycle match pulse and saturating match count.
// Latency: out and match_cnt reflect an accepted bit one clk later.
// No backpressure: bits are qualified by i_valid && en; SEQDET_CFG_EN adds a runtime pattern load.
module seq_detector_param
    import seq_detector_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = DEF_CNT_W
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i,
    input  logic               i_valid,
    input  logic               en,
    input  logic               clr_cnt,
`ifdef SEQDET_CFG_EN
    input  logic               cfg_we,
    input  logic [PAT_LEN-1:0] cfg_pat,
`endif
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy
);

    localparam logic [31:0] CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << CNT_W) - 32'd1);

    logic               accept;
    logic               match;
    logic               flush;
    logic               cfg_load;
    logic               full;
    fill_t              fill;
    logic [PAT_LEN-1:0] hist;
    logic [PAT_LEN-1:0] hist_nxt;
    logic [PAT_LEN-1:0] pat_cur;

`ifdef SEQDET_CFG_EN
    logic [PAT_LEN-1:0] pat_q;

    // Runtime pattern register; the new value is used from the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= PATTERN;
        end else if (cfg_we) begin
            pat_q <= cfg_pat;
        end
    end

    assign cfg_load = cfg_we;
    assign pat_cur  = pat_q;
`else
    assign cfg_load = 1'b0;
    assign pat_cur  = PATTERN;
`endif

    assign accept   = i_valid && en;
    assign hist_nxt = {hist[PAT_LEN-2:0], i};

    // A pattern load restarts the window and masks any match in that cycle.
    assign match = accept && full && (hist_nxt == pat_cur) && !cfg_load;
    assign flush = cfg_load || ((OVERLAP == 0) && match);

    seqdet_hist #(
        .PAT_LEN (PAT_LEN)
    ) u_hist (
        .clk   (clk),
        .rst   (rst),
        .i     (i),
        .shift (accept),
        .flush (flush),
        .hist  (hist),
        .fill  (fill),
        .full  (full)
    );

    // Registered match pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= 1'b0;
        end else begin
            out <= match;
        end
    end

    // Saturating match counter; a clear in a match cycle still counts that match.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt <= '0;
        end else if (clr_cnt) begin
            match_cnt <= match ? CNT_W'(1) : '0;
        end else if (match) begin
            match_cnt <= CNT_W'(sat_inc(32'(match_cnt), CNT_MAX));
        end
    end

    // Partial history is held whenever bits have been collected and no pulse is showing.
    assign busy = (fill != '0) && !out;

endmodule
